// File: rtl/ipa_seq_pkg.sv
// Shared opcodes and FSM state encoding for the IPA PE instruction sequencer.
// The optional hardware loop is enabled by defining IPA_SEQ_HWLOOP_EN.
package ipa_seq_pkg;

    localparam logic [4:0] OPC_NOP     = 5'b00000;
    localparam logic [4:0] OPC_JUMP    = 5'b10100;
    localparam logic [4:0] OPC_BRANCH  = 5'b10011;
    localparam logic [4:0] OPC_RESTART = 5'b11110;
    localparam logic [4:0] OPC_EXIT    = 5'b11111;
    localparam logic [4:0] OPC_STORE   = 5'b00111;
    localparam logic [4:0] OPC_LOAD    = 5'b01001;
    localparam logic [4:0] OPC_LOOPEND = 5'b10101;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        NOPWAIT,
        LSREQ,
        LSWAIT
    } seq_state_e;

endpackage

// File: rtl/ipa_pe_sequencer_if.sv
// Instruction-memory, condition/stall, issue and load/store signals of one PE sequencer.
// The master modport is the sequencer side; slave is the memory/datapath/array side.
interface ipa_pe_sequencer_if #(
    parameter int NB_PE   = 16,
    parameter int INST_W  = 20,
    parameter int IADDR_W = 7
) ();

    logic                Start_I;
    logic [IADDR_W-1:0]  Inst_Addr_O;
    logic                Inst_Req_O;
    logic [INST_W-1:0]   Inst_Data_I;
    logic [NB_PE-1:0]    Cond_In_I;
    logic [NB_PE-1:0]    Stall_In_I;
    logic                Issue_Valid_O;
    logic [INST_W-1:0]   Issue_Inst_O;
    logic                Ls_Req_O;
    logic                Ls_We_O;
    logic                Ls_Gnt_I;
    logic                Ls_Rvalid_I;
    logic                Stall_Out_O;
    logic                Busy_O;
    logic                End_Exec_O;

    modport master (
        input  Start_I, Inst_Data_I, Cond_In_I, Stall_In_I, Ls_Gnt_I, Ls_Rvalid_I,
        output Inst_Addr_O, Inst_Req_O, Issue_Valid_O, Issue_Inst_O,
               Ls_Req_O, Ls_We_O, Stall_Out_O, Busy_O, End_Exec_O
    );

    modport slave (
        output Start_I, Inst_Data_I, Cond_In_I, Stall_In_I, Ls_Gnt_I, Ls_Rvalid_I,
        input  Inst_Addr_O, Inst_Req_O, Issue_Valid_O, Issue_Inst_O,
               Ls_Req_O, Ls_We_O, Stall_Out_O, Busy_O, End_Exec_O
    );

endinterface

// File: rtl/ipa_seq_nop_counter.sv
// Loadable down-counter for multi-cycle NOPs; Freeze holds the count during global stalls.
// Last flags the final wait cycle so the sequencer can return to RUN.
module ipa_seq_nop_counter #(
    parameter int W = 5
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Load,
    input  logic [W-1:0] Load_Val,
    input  logic         Freeze,
    output logic         Last
);

    logic [W-1:0] count_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_reg <= '0;
        end else if (Load) begin
            count_reg <= Load_Val;
        end else if (!Freeze && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign Last = (count_reg == W'(1));

endmodule

// File: rtl/ipa_pe_sequencer.sv
// Per-PE instruction sequencer: fetch/decode, next-PC, NOP wait, LS handshake and issue.
// Define IPA_SEQ_HWLOOP_EN to add the single-level LOOPEND hardware loop (LOOP_W count).
module ipa_pe_sequencer
    import ipa_seq_pkg::*;
#(
    parameter int NB_PE   = 16,
    parameter int INST_W  = 20,
    parameter int IADDR_W = 7,
    parameter int NOP_W   = 5
`ifdef IPA_SEQ_HWLOOP_EN
    ,
    parameter int LOOP_W  = 8
`endif
) (
    input  logic               Clk,
    input  logic               Reset,
    ipa_pe_sequencer_if.master bus
);

    seq_state_e          state_reg, state_next;
    logic [IADDR_W-1:0]  pc_reg, pc_next, pc_inc;
    logic                is_store_reg, is_store_next;

    logic [INST_W-1:0]   inst_data;
    logic [NB_PE-1:0]    cond_vec, stall_vec;
    logic                glob_cond, glob_stall;

    logic [4:0]          opcode;
    logic [NOP_W-1:0]    op_nop_n;
    logic [IADDR_W-1:0]  tgt_a, tgt_b;

    logic                nop_load, nop_freeze, nop_last;
    logic [NOP_W-1:0]    nop_load_val;

    logic [IADDR_W-1:0]  inst_addr;
    logic                inst_req, issue_valid, ls_req, stall_out, end_exec;

    assign inst_data  = bus.Inst_Data_I;
    assign cond_vec   = bus.Cond_In_I;
    assign stall_vec  = bus.Stall_In_I;
    assign glob_cond  = |cond_vec;
    assign glob_stall = |stall_vec;

    assign opcode   = inst_data[4:0];
    assign op_nop_n = inst_data[5 +: NOP_W];
    assign tgt_a    = inst_data[5 +: IADDR_W];
    assign tgt_b    = inst_data[5 + IADDR_W +: IADDR_W];
    assign pc_inc   = pc_reg + IADDR_W'(1);

`ifdef IPA_SEQ_HWLOOP_EN
    logic [LOOP_W-1:0]   loop_cnt_reg, loop_cnt_next, op_loop_cnt;

    assign op_loop_cnt = inst_data[5 + IADDR_W +: LOOP_W];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            loop_cnt_reg <= '0;
        end else begin
            loop_cnt_reg <= loop_cnt_next;
        end
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= IDLE;
            pc_reg       <= '0;
            is_store_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            is_store_reg <= is_store_next;
        end
    end

    // The NOP counter only runs while waiting and never while the array is stalled.
    assign nop_freeze = glob_stall || (state_reg != NOPWAIT);

    ipa_seq_nop_counter #(
        .W (NOP_W)
    ) u_nop_counter (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (nop_load),
        .Load_Val (nop_load_val),
        .Freeze   (nop_freeze),
        .Last     (nop_last)
    );

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        is_store_next = is_store_reg;
        inst_addr     = '0;
        inst_req      = 1'b0;
        issue_valid   = 1'b0;
        ls_req        = 1'b0;
        stall_out     = 1'b0;
        end_exec      = 1'b0;
        nop_load      = 1'b0;
        nop_load_val  = op_nop_n - NOP_W'(1);
`ifdef IPA_SEQ_HWLOOP_EN
        loop_cnt_next = loop_cnt_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (bus.Start_I) begin
                    state_next = PRIME;
                    pc_next    = '0;
`ifdef IPA_SEQ_HWLOOP_EN
                    loop_cnt_next = '0;
`endif
                end
            end

            PRIME: begin
                inst_addr  = pc_reg;
                inst_req   = 1'b1;
                state_next = RUN;
            end

            RUN: begin
                inst_req  = 1'b1;
                inst_addr = pc_reg;
                if (!glob_stall) begin
                    pc_next = pc_inc;
                    case (opcode)
                        OPC_NOP: begin
                            if (op_nop_n > NOP_W'(1)) begin
                                nop_load   = 1'b1;
                                state_next = NOPWAIT;
                            end
                        end
                        OPC_JUMP:    pc_next = tgt_a;
                        OPC_BRANCH:  pc_next = glob_cond ? tgt_a : tgt_b;
                        OPC_RESTART: pc_next = '0;
                        OPC_EXIT: begin
                            end_exec   = 1'b1;
                            inst_req   = 1'b0;
                            pc_next    = '0;
                            state_next = IDLE;
`ifdef IPA_SEQ_HWLOOP_EN
                            loop_cnt_next = '0;
`endif
                        end
                        OPC_STORE: begin
                            issue_valid   = 1'b1;
                            is_store_next = 1'b1;
                            state_next    = LSREQ;
                        end
                        OPC_LOAD: begin
                            issue_valid   = 1'b1;
                            is_store_next = 1'b0;
                            state_next    = LSREQ;
                        end
`ifdef IPA_SEQ_HWLOOP_EN
                        OPC_LOOPEND: begin
                            // First visit arms the counter; the pass that sees 1 falls through.
                            if (loop_cnt_reg == '0) begin
                                if (op_loop_cnt > LOOP_W'(1)) begin
                                    loop_cnt_next = op_loop_cnt - LOOP_W'(1);
                                    pc_next       = tgt_a;
                                end
                            end else if (loop_cnt_reg > LOOP_W'(1)) begin
                                loop_cnt_next = loop_cnt_reg - LOOP_W'(1);
                                pc_next       = tgt_a;
                            end else begin
                                loop_cnt_next = '0;
                            end
                        end
`else
                        OPC_LOOPEND: issue_valid = 1'b1;
`endif
                        default:     issue_valid = 1'b1;
                    endcase
                    // Address the successor now so its word arrives next cycle: no bubble.
                    inst_addr = pc_next;
                end
            end

            NOPWAIT: begin
                inst_req  = 1'b1;
                inst_addr = pc_reg;
                if (!glob_stall && nop_last) begin
                    state_next = RUN;
                end
            end

            LSREQ: begin
                inst_req  = 1'b1;
                inst_addr = pc_reg;
                ls_req    = 1'b1;
                stall_out = 1'b1;
                if (bus.Ls_Gnt_I) begin
                    state_next = is_store_reg ? RUN : LSWAIT;
                end
            end

            LSWAIT: begin
                inst_req  = 1'b1;
                inst_addr = pc_reg;
                stall_out = 1'b1;
                if (bus.Ls_Rvalid_I) begin
                    state_next = RUN;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.Inst_Addr_O   = inst_addr;
    assign bus.Inst_Req_O    = inst_req;
    assign bus.Issue_Valid_O = issue_valid;
    assign bus.Issue_Inst_O  = issue_valid ? inst_data : '0;
    assign bus.Ls_Req_O      = ls_req;
    assign bus.Ls_We_O       = ls_req & is_store_reg;
    assign bus.Stall_Out_O   = stall_out;
    assign bus.Busy_O        = (state_reg != IDLE);
    assign bus.End_Exec_O    = end_exec;

endmodule

// File: tb/tb_ipa_pe_sequencer.sv
// Directed bench for ipa_pe_sequencer with a sync-read instruction memory model.
// Build with IPA_SEQ_HWLOOP_EN defined to exercise the hardware-loop case as well.
module tb_ipa_pe_sequencer;
    import ipa_seq_pkg::*;

    localparam int NB_PE   = 16;
    localparam int INST_W  = 20;
    localparam int IADDR_W = 7;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    ipa_pe_sequencer_if #(.NB_PE(NB_PE), .INST_W(INST_W), .IADDR_W(IADDR_W)) bus_if ();

    ipa_pe_sequencer u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_if.master)
    );

    logic [INST_W-1:0] mem [0:127];
    always @(posedge Clk) bus_if.Inst_Data_I <= mem[bus_if.Inst_Addr_O];

    int n_cmp = 0;
    int n_bad = 0;
    int issues, cyc, reqs, stalls, low;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    function automatic logic [INST_W-1:0] enc(input logic [4:0] opc, input logic [14:0] pay);
        return {pay, opc};
    endfunction
    function automatic logic [INST_W-1:0] f_add(input logic [14:0] pay);
        return enc(5'b00001, pay);
    endfunction
    function automatic logic [INST_W-1:0] f_nop(input logic [4:0] n);
        return enc(OPC_NOP, {10'd0, n});
    endfunction
    function automatic logic [INST_W-1:0] f_jump(input logic [6:0] t);
        return enc(OPC_JUMP, {8'd0, t});
    endfunction
    function automatic logic [INST_W-1:0] f_branch(input logic [6:0] a, input logic [6:0] b);
        return enc(OPC_BRANCH, {1'b0, b, a});
    endfunction
    function automatic logic [INST_W-1:0] f_loopend(input logic [6:0] t, input logic [7:0] c);
        return enc(OPC_LOOPEND, {c, t});
    endfunction

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = enc(OPC_EXIT, 15'd0);
    endtask

    // Leaves the DUT in PRIME (cycle 1 of the program).
    task automatic start_prog();
        tick();
        bus_if.Start_I = 1'b1;
        #1;
        check_eq("idle_busy", 32'(bus_if.Busy_O), 32'd0);
        tick();
        bus_if.Start_I = 1'b0;
        #1;
    endtask

    task automatic run_to_exit(output int n_iss, output int n_cyc);
        n_iss = 0;
        n_cyc = 0;
        while (!bus_if.End_Exec_O && n_cyc < 300) begin
            if (bus_if.Issue_Valid_O) n_iss++;
            tick();
            n_cyc++;
        end
        check_eq("exit_seen", 32'(bus_if.End_Exec_O), 32'd1);
        tick();
    endtask

    initial begin
        bus_if.Start_I     = 1'b0;
        bus_if.Cond_In_I   = '0;
        bus_if.Stall_In_I  = '0;
        bus_if.Ls_Gnt_I    = 1'b0;
        bus_if.Ls_Rvalid_I = 1'b0;
        clear_mem();
        #1;
        check_eq("rst_busy",  32'(bus_if.Busy_O),        32'd0);
        check_eq("rst_req",   32'(bus_if.Inst_Req_O),    32'd0);
        check_eq("rst_issue", 32'(bus_if.Issue_Valid_O), 32'd0);
        check_eq("rst_lsreq", 32'(bus_if.Ls_Req_O),      32'd0);
        tick();
        tick();
        Reset = 1'b0;

        // ADD, ADD, EXIT with a stray Start_I mid-run
        $display("-- basic");
        clear_mem();
        mem[0] = f_add(15'h0a1); mem[1] = f_add(15'h0b2);
        start_prog();
        check_eq("prime_addr", 32'(bus_if.Inst_Addr_O), 32'd0);
        check_eq("prime_req",  32'(bus_if.Inst_Req_O),  32'd1);
        check_eq("prime_iss",  32'(bus_if.Issue_Valid_O), 32'd0);
        tick();
        check_eq("c2_iss",  32'(bus_if.Issue_Valid_O), 32'd1);
        check_eq("c2_inst", 32'(bus_if.Issue_Inst_O),  32'(mem[0]));
        check_eq("c2_addr", 32'(bus_if.Inst_Addr_O),   32'd1);
        tick();
        bus_if.Start_I = 1'b1;
        #1;
        check_eq("c3_iss",  32'(bus_if.Issue_Valid_O), 32'd1);
        check_eq("c3_inst", 32'(bus_if.Issue_Inst_O),  32'(mem[1]));
        tick();
        bus_if.Start_I = 1'b0;
        #1;
        check_eq("c4_end", 32'(bus_if.End_Exec_O),    32'd1);
        check_eq("c4_iss", 32'(bus_if.Issue_Valid_O), 32'd0);
        tick();
        check_eq("c5_busy", 32'(bus_if.Busy_O),     32'd0);
        check_eq("c5_end",  32'(bus_if.End_Exec_O), 32'd0);

        // NOP n=4 at address 1
        $display("-- nop4");
        clear_mem();
        mem[0] = f_add(15'h011); mem[1] = f_nop(5'd4); mem[2] = f_add(15'h022);
        start_prog();
        tick();
        tick();
        low = 0;
        while (!bus_if.Issue_Valid_O && low < 20) begin
            check_eq("nop_addr", 32'(bus_if.Inst_Addr_O), 32'd2);
            low++;
            tick();
        end
        check_eq("nop_low",  32'(low), 32'd4);
        check_eq("nop_next", 32'(bus_if.Issue_Inst_O), 32'(mem[2]));
        run_to_exit(issues, cyc);

        // NOP n=0 and n=1 take one cycle each
        $display("-- nop0/1");
        clear_mem();
        mem[0] = f_nop(5'd0); mem[1] = f_nop(5'd1); mem[2] = f_add(15'h033);
        start_prog();
        run_to_exit(issues, cyc);
        check_eq("nop01_iss", 32'(issues), 32'd1);
        check_eq("nop01_cyc", 32'(cyc),    32'd4);

        // BRANCH on the OR of the condition flags
        for (int k = 0; k < 2; k++) begin
            logic [6:0] exp_t;
            $display("-- branch cond=%0d", k);
            clear_mem();
            mem[0] = f_branch(7'h10, 7'h20);
            mem[7'h10] = f_add(15'h1a1); mem[7'h20] = f_add(15'h2b2);
            bus_if.Cond_In_I = (k == 0) ? 16'h0000 : 16'h0100;
            exp_t = (k == 0) ? 7'h20 : 7'h10;
            start_prog();
            tick();
            check_eq("br_addr", 32'(bus_if.Inst_Addr_O),   32'(exp_t));
            check_eq("br_iss",  32'(bus_if.Issue_Valid_O), 32'd0);
            tick();
            check_eq("br_tgt_iss",  32'(bus_if.Issue_Valid_O), 32'd1);
            check_eq("br_tgt_inst", 32'(bus_if.Issue_Inst_O),  32'(mem[exp_t]));
            run_to_exit(issues, cyc);
        end
        bus_if.Cond_In_I = '0;

        // JUMP then RESTART loop, aborted by reset
        $display("-- jump/restart");
        clear_mem();
        mem[0] = f_jump(7'h05); mem[5] = f_add(15'h055); mem[6] = enc(OPC_RESTART, 15'd0);
        start_prog();
        tick();
        check_eq("jmp_addr", 32'(bus_if.Inst_Addr_O), 32'd5);
        tick();
        check_eq("jmp_inst", 32'(bus_if.Issue_Inst_O), 32'(mem[5]));
        tick();
        check_eq("rst_pc_addr", 32'(bus_if.Inst_Addr_O),   32'd0);
        check_eq("rst_pc_iss",  32'(bus_if.Issue_Valid_O), 32'd0);
        tick();
        check_eq("rst_pc_jmp", 32'(bus_if.Inst_Addr_O), 32'd5);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        check_eq("abort_busy", 32'(bus_if.Busy_O), 32'd0);

        // LOAD: grant on 3rd request cycle (with an ignored rvalid), rvalid 2 cycles later
        $display("-- load");
        clear_mem();
        mem[0] = enc(OPC_LOAD, 15'h123); mem[1] = f_add(15'h044);
        start_prog();
        tick();
        check_eq("ld_iss",   32'(bus_if.Issue_Valid_O), 32'd1);
        check_eq("ld_inst",  32'(bus_if.Issue_Inst_O),  32'(mem[0]));
        check_eq("ld_req0",  32'(bus_if.Ls_Req_O),      32'd0);
        reqs = 0;
        stalls = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            bus_if.Ls_Gnt_I    = (c == 2);
            bus_if.Ls_Rvalid_I = (c == 2) || (c == 4);
            #1;
            if (bus_if.Ls_Req_O) begin
                reqs++;
                check_eq("ld_we", 32'(bus_if.Ls_We_O), 32'd0);
            end
            if (bus_if.Stall_Out_O) stalls++;
            check_eq("ld_addr", 32'(bus_if.Inst_Addr_O), 32'd1);
        end
        tick();
        bus_if.Ls_Gnt_I    = 1'b0;
        bus_if.Ls_Rvalid_I = 1'b0;
        #1;
        check_eq("ld_reqs",   32'(reqs),   32'd3);
        check_eq("ld_stalls", 32'(stalls), 32'd5);
        check_eq("ld_resume", 32'(bus_if.Issue_Inst_O), 32'(mem[1]));
        check_eq("ld_nostall", 32'(bus_if.Stall_Out_O), 32'd0);
        run_to_exit(issues, cyc);

        // STORE granted immediately
        $display("-- store");
        clear_mem();
        mem[0] = enc(OPC_STORE, 15'h321); mem[1] = f_add(15'h066);
        start_prog();
        tick();
        tick();
        bus_if.Ls_Gnt_I = 1'b1;
        #1;
        check_eq("st_req",   32'(bus_if.Ls_Req_O),    32'd1);
        check_eq("st_we",    32'(bus_if.Ls_We_O),     32'd1);
        check_eq("st_stall", 32'(bus_if.Stall_Out_O), 32'd1);
        tick();
        bus_if.Ls_Gnt_I = 1'b0;
        #1;
        check_eq("st_req_off", 32'(bus_if.Ls_Req_O),     32'd0);
        check_eq("st_resume",  32'(bus_if.Issue_Inst_O), 32'(mem[1]));
        run_to_exit(issues, cyc);

        // Global stall from PE 2 for 3 cycles
        $display("-- stall");
        clear_mem();
        mem[0] = f_add(15'h101); mem[1] = f_add(15'h202); mem[2] = f_add(15'h303);
        start_prog();
        tick();
        tick();
        bus_if.Stall_In_I = 16'h0004;
        #1;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) tick();
            check_eq("stl_iss",  32'(bus_if.Issue_Valid_O), 32'd0);
            check_eq("stl_addr", 32'(bus_if.Inst_Addr_O),   32'd1);
            check_eq("stl_req",  32'(bus_if.Inst_Req_O),    32'd1);
        end
        tick();
        bus_if.Stall_In_I = '0;
        #1;
        check_eq("stl_resume", 32'(bus_if.Issue_Inst_O), 32'(mem[1]));
        check_eq("stl_addr2",  32'(bus_if.Inst_Addr_O),  32'd2);
        run_to_exit(issues, cyc);
        check_eq("stl_tail_iss", 32'(issues), 32'd2);

        // Reset while requesting a store
        $display("-- reset in LSREQ");
        clear_mem();
        mem[0] = enc(OPC_STORE, 15'h0);
        start_prog();
        tick();
        tick();
        check_eq("pre_rst_req", 32'(bus_if.Ls_Req_O), 32'd1);
        Reset = 1'b1;
        #1;
        check_eq("ar_req",   32'(bus_if.Ls_Req_O),    32'd0);
        check_eq("ar_stall", 32'(bus_if.Stall_Out_O), 32'd0);
        check_eq("ar_busy",  32'(bus_if.Busy_O),      32'd0);
        check_eq("ar_ireq",  32'(bus_if.Inst_Req_O),  32'd0);
        tick();
        Reset = 1'b0;
        tick();
        check_eq("ar_idle", 32'(bus_if.Busy_O), 32'd0);

        // Opcode 10101 with zero loop count
        $display("-- opcode 10101");
        clear_mem();
        mem[0] = f_loopend(7'h00, 8'd0);
        start_prog();
        run_to_exit(issues, cyc);
`ifdef IPA_SEQ_HWLOOP_EN
        check_eq("op15_iss", 32'(issues), 32'd0);

        $display("-- hw loop cnt=3");
        clear_mem();
        mem[0] = f_add(15'h0c1); mem[1] = f_add(15'h0c2); mem[2] = f_loopend(7'h00, 8'd3);
        start_prog();
        run_to_exit(issues, cyc);
        check_eq("loop_iss", 32'(issues), 32'd6);
        check_eq("loop_cyc", 32'(cyc),    32'd10);
`else
        check_eq("op15_iss", 32'(issues), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
